// File: rtl/osecpu_dr_uart_dump_pkg.sv
// Shared constants, state encodings and ASCII helpers for the dr/pc UART dumper.
package osecpu_dr_uart_dump_pkg;

  localparam int unsigned LINE_LEN = 15;

  localparam logic [7:0] ASCII_COLON    = 8'h3A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_HEX0     = 8'h30;
  localparam logic [7:0] ASCII_HEXA_OFS = 8'h37;

  typedef enum logic [1:0] {LINE_IDLE, LINE_START, LINE_SEND} line_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] dr;
  } snap_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_HEX0 + {4'h0, n} : ASCII_HEXA_OFS + {4'h0, n};
  endfunction

  // Character idx of the line "PPPP:DDDDDDDD\r\n" built from snapshot s.
  function automatic logic [7:0] line_char(input logic [3:0] idx, input snap_t s);
    logic [15:0] pc_sh;
    logic [31:0] dr_sh;
    logic [3:0]  k;
    pc_sh = s.pc << {idx[1:0], 2'b00};
    k     = idx - 4'd5;
    dr_sh = s.dr << {k[2:0], 2'b00};
    if (idx < 4'd4)       return hex_ascii(pc_sh[15:12]);
    else if (idx == 4'd4) return ASCII_COLON;
    else if (idx < 4'd13) return hex_ascii(dr_sh[31:28]);
    else if (idx == 4'd13) return ASCII_CR;
    else                  return ASCII_LF;
  endfunction

endpackage

// File: rtl/osecpu_dr_uart_dump_tx_byte.sv
// 8N1 byte transmitter; a new load is accepted in the last stop-bit cycle for gapless streaming.
module osecpu_dr_uart_dump_tx_byte
  import osecpu_dr_uart_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       sh, sh_nxt;
  logic             tx_nxt;
  logic             bit_end;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign done_c  = (state == TX_STOP) && bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      sh      <= sh_nxt;
      tx      <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    sh_nxt    = sh;
    tx_nxt    = tx;
    if (state != TX_IDLE) cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
    case (state)
      TX_START: if (bit_end) begin
        tx_nxt    = sh[0];
        bit_nxt   = '0;
        state_nxt = TX_DATA;
      end
      TX_DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
          tx_nxt    = 1'b1;
          state_nxt = TX_STOP;
        end else begin
          bit_nxt = bit_idx + 3'd1;
          sh_nxt  = {1'b0, sh[7:1]};
          tx_nxt  = sh[1];
        end
      end
      TX_STOP: if (bit_end) state_nxt = TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
    if (load) begin
      state_nxt = TX_START;
      cnt_nxt   = '0;
      bit_nxt   = '0;
      sh_nxt    = data;
      tx_nxt    = 1'b0;
    end
  end

endmodule

// File: rtl/osecpu_dr_uart_dump.sv
// Watches dr for changes (or a send strobe) and dumps "PPPP:DDDDDDDD\r\n" over an 8N1 UART.
module osecpu_dr_uart_dump
  import osecpu_dr_uart_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DROP_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       dr,
  input  logic [15:0]       pc,
  input  logic              send,
  output logic              tx,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [1:0]  rst_sync;
  logic        rst_n;
  line_state_t state, state_nxt;
  logic [3:0]  char_idx, idx_nxt;
  snap_t       snap, snap_nxt, pend, pend_nxt, live, next_line;
  logic        pending, pending_nxt, busy_nxt;
  logic [DROP_W-1:0] drop_nxt;
  logic [31:0] dr_prev;
  logic        event_c, done_c, last_c, load_c;
  logic [7:0]  byte_c;

  // Async assert, sync deassert
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign live      = '{pc: pc, dr: dr};
  assign event_c   = (dr != dr_prev) | send;
  assign last_c    = done_c && (char_idx == 4'(LINE_LEN - 1));
  assign next_line = pending ? pend : live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LINE_IDLE;
      char_idx <= '0;
      snap     <= '0;
      pend     <= '0;
      pending  <= 1'b0;
      busy     <= 1'b0;
      drop_cnt <= '0;
      dr_prev  <= '0;
    end else begin
      state    <= state_nxt;
      char_idx <= idx_nxt;
      snap     <= snap_nxt;
      pend     <= pend_nxt;
      pending  <= pending_nxt;
      busy     <= busy_nxt;
      drop_cnt <= drop_nxt;
      dr_prev  <= dr;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = char_idx;
    snap_nxt    = snap;
    pend_nxt    = pend;
    pending_nxt = pending;
    busy_nxt    = busy;
    drop_nxt    = drop_cnt;
    load_c      = 1'b0;
    byte_c      = line_char(char_idx, snap);
    case (state)
      LINE_IDLE: if (event_c) begin
        snap_nxt  = live;
        busy_nxt  = 1'b1;
        idx_nxt   = '0;
        state_nxt = LINE_START;
      end
      LINE_START: begin
        load_c    = 1'b1;
        state_nxt = LINE_SEND;
      end
      LINE_SEND: if (done_c) begin
        if (!last_c) begin
          load_c  = 1'b1;
          idx_nxt = char_idx + 4'd1;
          byte_c  = line_char(char_idx + 4'd1, snap);
        end else if (pending || event_c) begin
          // Chain straight into the next line without an idle gap
          load_c   = 1'b1;
          idx_nxt  = '0;
          snap_nxt = next_line;
          byte_c   = line_char(4'd0, next_line);
        end else begin
          busy_nxt  = 1'b0;
          state_nxt = LINE_IDLE;
        end
      end
      default: state_nxt = LINE_IDLE;
    endcase
    // Updates during a line: latest wins, overwritten ones are counted
    if (busy && event_c && !(last_c && !pending)) begin
      pend_nxt    = live;
      pending_nxt = 1'b1;
      if (pending && !last_c && drop_cnt != '1) drop_nxt = drop_cnt + DROP_W'(1);
    end else if (last_c && pending) begin
      pending_nxt = 1'b0;
    end
  end

  osecpu_dr_uart_dump_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_c),
    .data   (byte_c),
    .tx     (tx),
    .done_c (done_c)
  );

endmodule

// File: tb/tb_osecpu_dr_uart_dump.sv
// Bench for osecpu_dr_uart_dump: decodes the UART stream and checks lines, timing and drop counting.
module tb_osecpu_dr_uart_dump;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        send = 1'b0;
  logic [31:0] dr = '0;
  logic [15:0] pc = '0;
  logic        tx, busy;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  byte unsigned rxq[$];
  int           fstart[$];
  int  busy_rise = 0, busy_fall = 0;
  logic busy_q = 1'b0;
  logic samp[40];
  int   nsamp = 0;
  bit   rx_active = 1'b0;
  bit   frame_ok;
  byte unsigned frame_byte;

  typedef struct {
    logic [31:0] dr;
    logic [15:0] pc;
    string       line;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  osecpu_dr_uart_dump #(.CLKS_PER_BIT(CPB), .DROP_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .dr       (dr),
    .pc       (pc),
    .send     (send),
    .tx       (tx),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Busy edge timestamps and a sample-per-cycle UART receiver
  always @(negedge clk) begin
    if (busy && !busy_q) busy_rise = cyc;
    if (!busy && busy_q) busy_fall = cyc;
    busy_q = busy;
    if (!reset) begin
      rx_active = 1'b0;
      nsamp = 0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1'b1;
        samp[0] = 1'b0;
        nsamp = 1;
        fstart.push_back(cyc);
      end
    end else begin
      samp[nsamp] = tx;
      nsamp++;
      if (nsamp == 40) begin
        frame_ok = 1'b1;
        frame_byte = 8'h00;
        for (int k = 0; k < 10; k++)
          for (int j = 1; j < 4; j++)
            if (samp[k*4+j] !== samp[k*4]) frame_ok = 1'b0;
        if (samp[0] !== 1'b0 || samp[36] !== 1'b1) frame_ok = 1'b0;
        for (int k = 0; k < 8; k++) frame_byte[k] = samp[4+4*k];
        total++;
        if (!frame_ok) begin
          bad++;
          $display("FAIL uart_frame at cycle %0d: malformed bit samples, required 4-cycle start/data/stop bits", cyc);
        end
        rxq.push_back(frame_byte);
        rx_active = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_s(input string name, input string got, input string exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
    end
  endtask

  function automatic string hex_str(input logic [31:0] v, input int n);
    string s = "";
    logic [3:0] nb;
    for (int i = n - 1; i >= 0; i--) begin
      nb = 4'(v >> (4 * i));
      if (nb < 4'd10) s = $sformatf("%s%c", s, 8'(48 + int'(nb)));
      else            s = $sformatf("%s%c", s, 8'(65 + int'(nb) - 10));
    end
    return s;
  endfunction

  function automatic string exp_line(input logic [15:0] p, input logic [31:0] d);
    return {hex_str({16'h0, p}, 4), ":", hex_str(d, 8)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for busy to rise, then for it to fall
  task automatic wait_idle(input string name);
    int n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    chk({name, "_busy_rise"}, 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk({name, "_busy_fall"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic take_line(input string name, output string s);
    byte unsigned b;
    s = "";
    chk({name, "_len"}, 64'(rxq.size() >= 15), 64'd1);
    if (rxq.size() >= 15) begin
      for (int i = 0; i < 13; i++) begin
        b = rxq.pop_front();
        s = $sformatf("%s%c", s, b);
      end
      chk({name, "_cr"}, 64'(rxq.pop_front()), 64'h0D);
      chk({name, "_lf"}, 64'(rxq.pop_front()), 64'h0A);
    end else begin
      rxq.delete();
    end
  endtask

  task automatic clear_rx();
    rxq.delete();
    fstart.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string line;
    int    tx_low;
    logic [31:0] last_dr, r;
    logic [15:0] p;

    vecs[0] = '{32'h12AB34CD, 16'h0042, "0042:12AB34CD"};
    vecs[1] = '{32'hFFFFFFFF, 16'hFFFF, "FFFF:FFFFFFFF"};
    vecs[2] = '{32'h00000000, 16'h1234, "1234:00000000"};
    vecs[3] = '{32'h9A0F5E61, 16'hA09F, "A09F:9A0F5E61"};
    vecs[4] = '{32'h80000009, 16'h0001, "0001:80000009"};

    // Reset and quiet idle with dr=0
    repeat (3) @(negedge clk);
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk) reset = 1'b1;
    tx_low = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) tx_low++;
    end
    chk("idle_quiet_cycles", 64'(tx_low), 64'd0);
    chk("idle_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("idle_no_frames", 64'(rxq.size()), 64'd0);

    // Table-driven single lines
    for (int v = 0; v < 5; v++) begin
      clear_rx();
      step();
      dr = vecs[v].dr;
      pc = vecs[v].pc;
      wait_idle($sformatf("vec%0d", v));
      take_line($sformatf("vec%0d", v), line);
      chk_s($sformatf("vec%0d_line", v), line, vecs[v].line);
      chk($sformatf("vec%0d_frames", v), 64'(fstart.size()), 64'd15);
      chk($sformatf("vec%0d_busy_len", v), 64'(busy_fall - busy_rise), 64'd601);
      if (fstart.size() >= 15) begin
        chk($sformatf("vec%0d_tx_lag", v), 64'(fstart[0] - busy_rise), 64'd1);
        chk($sformatf("vec%0d_char_pitch", v), 64'(fstart[14] - fstart[0]), 64'd560);
      end
      chk($sformatf("vec%0d_drop", v), 64'(drop_cnt), 64'd0);
    end

    // Two updates during a line: one overwritten, gapless follow-on line
    clear_rx();
    step();
    dr = 32'h1; pc = 16'h0003;
    repeat (50) step();
    dr = 32'h2;
    repeat (50) step();
    dr = 32'h3;
    wait_idle("pend");
    take_line("pend_l1", line);
    chk_s("pend_l1_line", line, "0003:00000001");
    take_line("pend_l2", line);
    chk_s("pend_l2_line", line, "0003:00000003");
    chk("pend_frames", 64'(fstart.size()), 64'd30);
    if (fstart.size() >= 30) chk("pend_no_gap", 64'(fstart[15] - fstart[0]), 64'd600);
    chk("pend_busy_len", 64'(busy_fall - busy_rise), 64'd1201);
    chk("pend_drop", 64'(drop_cnt), 64'd1);

    // send strobe with dr unchanged, then send coincident with a change
    step();
    dr = 32'hDEADBEEF; pc = 16'h0100;
    wait_idle("send_pre");
    clear_rx();
    step(); send = 1'b1;
    step(); send = 1'b0;
    wait_idle("send");
    repeat (700) step();
    chk("send_bytes", 64'(rxq.size()), 64'd15);
    take_line("send", line);
    chk_s("send_line", line, "0100:DEADBEEF");
    clear_rx();
    step(); dr = 32'hCAFE0001; pc = 16'h0101; send = 1'b1;
    step(); send = 1'b0;
    wait_idle("send_chg");
    repeat (100) step();
    chk("send_chg_bytes", 64'(rxq.size()), 64'd15);
    take_line("send_chg", line);
    chk_s("send_chg_line", line, "0101:CAFE0001");

    // Reset in the middle of a line
    clear_rx();
    step();
    dr = 32'h5A5A5A5A; pc = 16'h0200;
    repeat (101) step();
    reset = 1'b0;
    #1;
    chk("midrst_tx", 64'(tx), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_drop", 64'(drop_cnt), 64'd0);
    dr = 32'h5; pc = 16'h0007;
    repeat (5) step();
    clear_rx();
    @(negedge clk) reset = 1'b1;
    wait_idle("postrst");
    repeat (50) step();
    chk("postrst_frames", 64'(fstart.size()), 64'd15);
    take_line("postrst", line);
    chk_s("postrst_line", line, "0007:00000005");

    // 300 updates during one line: counter saturates, last value wins
    clear_rx();
    step();
    dr = 32'h100; pc = 16'h0300;
    for (int i = 0; i < 300; i++) begin
      step();
      dr = dr + 32'(1 + $urandom_range(0, 255));
    end
    last_dr = dr;
    wait_idle("sat");
    chk("sat_drop", 64'(drop_cnt), 64'hFF);
    take_line("sat_l1", line);
    chk_s("sat_l1_line", line, "0300:00000100");
    take_line("sat_l2", line);
    chk_s("sat_l2_line", line, exp_line(16'h0300, last_dr));
    chk("sat_no_extra", 64'(rxq.size()), 64'd0);

    // Random single lines against the formatted reference
    for (int i = 0; i < 8; i++) begin
      clear_rx();
      r = $urandom;
      if (r == dr) r = r ^ 32'h1;
      p = 16'($urandom);
      step();
      dr = r; pc = p;
      wait_idle($sformatf("rnd%0d", i));
      take_line($sformatf("rnd%0d", i), line);
      chk_s($sformatf("rnd%0d_line", i), line, exp_line(p, r));
      chk($sformatf("rnd%0d_drop", i), 64'(drop_cnt), 64'hFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
